rr_grant_fsm: RTL

- Round-robin grant engine feeding the arbiter's grant output register.
- Samples a request vector and picks one winner by rotating priority.
- Offers the winner as a one-hot vector with a `load` strobe and holds it until the downstream register accepts it with `ack`.
- Keeps the grant until the winner drops its request, then advances priority past the winner.

---
 rtl/rr_grant_fsm.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/rr_grant_fsm.sv
// -----------------------------------------------------------------------------
// rr_grant_fsm
//
// Round-robin grant engine that feeds the arbiter's grant output register.
// A request vector is sampled in IDLE and one winner is picked by rotating
// priority starting at ptr. The winner is offered as a one-hot vector with a
// load strobe and held until the downstream register accepts it with ack.
// The grant then stays in place until the winner drops its request. At that
// point priority advances past the winner.
//
// Handshake (load/ack): load is high exactly while the FSM is in OFFER, with
// grant/grant_idx stable. The offer is accepted on the rising edge where
// load=1, ack=1 and the winner still requests; the downstream register
// captures grant on that same edge. If the winner withdraws, the offer is
// cancelled even when ack is high. ack is ignored outside OFFER.
//
// Optional feature (macro RR_TIMEOUT_EN):
//   defined   - a BUSY cycle counter forces release after TIMEOUT BUSY
//               cycles and pulses timeout for one cycle.
//   undefined - no counter; timeout is tied to 0; grants are held as long
//               as the winner keeps requesting.
//
// Parameters:
//   WIDTH     number of requesters (2..32)
//   IDXW      width of grant_idx, derived from WIDTH
//   TIMEOUT   maximum BUSY cycles per grant with RR_TIMEOUT_EN (2..65535)
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-low reset
//   req        in   [WIDTH] request vector
//   ack        in   downstream accepts the offered grant (OFFER only)
//   grant      out  [WIDTH] registered one-hot grant, 0 when none
//   grant_idx  out  [IDXW]  registered binary index of grant, 0 when none
//   load       out  registered, high while in OFFER
//   busy       out  registered, high while in OFFER or BUSY
//   timeout    out  registered one-cycle pulse on forced release
//   dbg_state  out  [2] current FSM state (0 IDLE, 1 OFFER, 2 BUSY)
//   dbg_ptr    out  [IDXW] current highest-priority index
// -----------------------------------------------------------------------------
module rr_grant_fsm #(
  parameter  int WIDTH   = 4,
  parameter  int TIMEOUT = 16,
  localparam int IDXW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  input  logic             ack,
  output logic [WIDTH-1:0] grant,
  output logic [IDXW-1:0]  grant_idx,
  output logic             load,
  output logic             busy,
  output logic             timeout,
  output logic [1:0]       dbg_state,
  output logic [IDXW-1:0]  dbg_ptr
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("rr_grant_fsm: WIDTH must be in the range 2..32");
  end

  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("rr_grant_fsm: TIMEOUT must be in the range 2..65535");
  end

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam logic [IDXW-1:0]  LAST_IDX  = IDXW'(WIDTH - 1);
  localparam logic [IDXW:0]    WIDTH_EXT = (IDXW + 1)'(WIDTH);
  localparam logic [WIDTH-1:0] ONE_HOT0  = WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OFFER = 2'd1,
    ST_BUSY  = 2'd2
  } state_t;

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  state_t           state_q,     state_d;
  logic [IDXW-1:0]  ptr_q,       ptr_d;
  logic [WIDTH-1:0] grant_q,     grant_d;
  logic [IDXW-1:0]  grant_idx_q, grant_idx_d;
  logic             load_q,      load_d;
  logic             busy_q,      busy_d;

  // High in the BUSY cycle that is about to force a release.
  logic             cnt_expired;
  // High when the release taken this cycle is a forced one.
  logic             forced_rel;

  // ---------------------------------------------------------------------------
  // Rotating-priority winner selection
  // ---------------------------------------------------------------------------
  // req_rot[k] is req[(ptr + k) mod WIDTH]: the doubled vector shifted right
  // by ptr puts the scan order at bit 0 upwards without any modulo logic.
  logic [WIDTH-1:0] req_rot;
  logic [IDXW-1:0]  win_off;
  logic [IDXW:0]    win_sum;
  logic [IDXW-1:0]  win_idx;
  logic [WIDTH-1:0] win_onehot;
  logic             req_any;

  assign req_rot = WIDTH'({req, req} >> ptr_q);
  assign req_any = |req;

  // Lowest set bit of the rotated vector is the offset of the winner from
  // ptr; scanning downwards lets the lowest index overwrite the others.
  always_comb begin
    win_off = '0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        win_off = IDXW'(k);
      end
    end
  end

  // ptr + offset can exceed WIDTH-1; wrap explicitly so non-power-of-2
  // widths never rely on IDXW overflow.
  always_comb begin
    win_sum = {1'b0, ptr_q} + {1'b0, win_off};
    if (win_sum >= WIDTH_EXT) begin
      win_sum = win_sum - WIDTH_EXT;
    end
    win_idx = win_sum[IDXW-1:0];
  end

  assign win_onehot = ONE_HOT0 << win_idx;

  // ---------------------------------------------------------------------------
  // Holder status and next priority pointer
  // ---------------------------------------------------------------------------
  // grant_q is one-hot or zero, so masking avoids indexing req with a
  // value that could be out of range for non-power-of-2 widths.
  logic            holder_req;
  logic [IDXW-1:0] ptr_next;

  assign holder_req = |(req & grant_q);
  assign ptr_next   = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + 1'b1;

  // ---------------------------------------------------------------------------
  // Optional BUSY timeout counter
  // ---------------------------------------------------------------------------
`ifdef RR_TIMEOUT_EN
  localparam int             CNTW     = $clog2(TIMEOUT + 1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            timeout_q, timeout_d;

  assign cnt_expired = (state_q == ST_BUSY) && (cnt_q == CNT_LAST);

  // Counter is zero on entry to BUSY and counts every BUSY cycle the grant
  // survives. It never passes CNT_LAST because that cycle always releases.
  always_comb begin
    cnt_d = '0;
    if (state_q == ST_BUSY && state_d == ST_BUSY) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign timeout_d = forced_rel;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign cnt_expired = 1'b0;
  assign timeout     = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM next-state and registered-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    grant_idx_d = grant_idx_q;
    load_d      = load_q;
    busy_d      = busy_q;
    forced_rel  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        grant_d     = '0;
        grant_idx_d = '0;
        load_d      = 1'b0;
        busy_d      = 1'b0;
        if (req_any) begin
          grant_d     = win_onehot;
          grant_idx_d = win_idx;
          load_d      = 1'b1;
          busy_d      = 1'b1;
          state_d     = ST_OFFER;
        end
      end

      ST_OFFER: begin
        // Withdrawal beats ack; priority is not advanced for a grant that
        // was never accepted.
        if (!holder_req) begin
          grant_d     = '0;
          grant_idx_d = '0;
          load_d      = 1'b0;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end else if (ack) begin
          load_d  = 1'b0;
          state_d = ST_BUSY;
        end
      end

      ST_BUSY: begin
        load_d = 1'b0;
        // A normal release on the same edge as expiry wins, so the forced
        // flag is only raised while the winner still requests.
        if (!holder_req || cnt_expired) begin
          forced_rel  = holder_req;
          grant_d     = '0;
          grant_idx_d = '0;
          busy_d      = 1'b0;
          ptr_d       = ptr_next;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        grant_d     = '0;
        grant_idx_d = '0;
        load_d      = 1'b0;
        busy_d      = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      grant_idx_q <= '0;
      load_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      grant_idx_q <= grant_idx_d;
      load_q      <= load_d;
      busy_q      <= busy_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign grant     = grant_q;
  assign grant_idx = grant_idx_q;
  assign load      = load_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;
  assign dbg_ptr   = ptr_q;

endmodule
